// File: rtl/game_pkg.sv
// Shared types and defaults for the game controller: state encoding,
// default timing/limit parameters and the score saturation helper.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam int TICK_DIV_DEFAULT     = 833333;
    localparam int TOP_LIMIT_DEFAULT    = 44;
    localparam int BOTTOM_LIMIT_DEFAULT = 479;
    localparam int DIE_CYCLES_DEFAULT   = 25000000;

    localparam int LOC_W   = 9;
    localparam int SCORE_W = 16;

    function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] value);
        return (value == {SCORE_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle of the controller's button, player-datapath and status signals.
// master = the controller, slave = the environment (buttons + player datapath).
interface game_ctrl_if;
    import game_pkg::*;

    logic                start;
    logic                flip;
    logic [LOC_W-1:0]    luc_loc;
    logic                collision;
    logic                player_rst_n;
    logic                player_en;
    logic                move_tick;
    logic                grv_req;
    logic [1:0]          state;
    logic [SCORE_W-1:0]  score;

    modport master (
        input  start, flip, luc_loc, collision,
        output player_rst_n, player_en, move_tick, grv_req, state, score
    );

    modport slave (
        output start, flip, luc_loc, collision,
        input  player_rst_n, player_en, move_tick, grv_req, state, score
    );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector: pulse is a registered one-cycle event in the cycle
// after a 0->1 transition of level has been sampled.
module edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level,
    output logic pulse
);

    logic level_d_reg;
    logic pulse_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_d_reg <= 1'b0;
            pulse_reg   <= 1'b0;
        end else begin
            level_d_reg <= level;
            pulse_reg   <= level & ~level_d_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: run/dying/over sequencing, move-tick generation,
// gated gravity-flip requests and a saturating survival score.
module game_ctrl
    import game_pkg::*;
#(
    parameter int TickDiv     = TICK_DIV_DEFAULT,
    parameter int TopLimit    = TOP_LIMIT_DEFAULT,
    parameter int BottomLimit = BOTTOM_LIMIT_DEFAULT,
    parameter int DieCycles   = DIE_CYCLES_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    game_ctrl_if.master  bus
);

    localparam int TickW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int DieW  = (DieCycles > 1) ? $clog2(DieCycles) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);
    localparam logic [DieW-1:0]  DieLast  = DieW'(DieCycles - 1);

    game_state_e         state_reg;
    game_state_e         state_next;
    logic [TickW-1:0]    tick_cnt_reg;
    logic [DieW-1:0]     die_cnt_reg;
    logic                pending_reg;
    logic [SCORE_W-1:0]  score_reg;
    logic                player_rst_n_reg;

    logic start_pulse;
    logic flip_pulse;
    logic in_run;
    logic move_tick;
    logic out_of_bounds;
    logic fatal_tick;
    logic run_entry;

    edge_detect u_start_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .level (bus.start),
        .pulse (start_pulse)
    );

    edge_detect u_flip_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .level (bus.flip),
        .pulse (flip_pulse)
    );

    assign in_run        = (state_reg == ST_RUN);
    assign move_tick     = in_run && (tick_cnt_reg == TickLast);
    assign out_of_bounds = (bus.luc_loc <= LOC_W'(TopLimit)) || (bus.luc_loc >= LOC_W'(BottomLimit));
    assign fatal_tick    = move_tick && out_of_bounds;
    assign run_entry     = (state_next == ST_RUN) && !in_run;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE, ST_OVER: if (start_pulse)              state_next = ST_RUN;
            ST_RUN:           if (fatal_tick)               state_next = ST_DYING;
            ST_DYING:         if (die_cnt_reg == DieLast)   state_next = ST_OVER;
            default:                                        state_next = ST_IDLE;
        endcase
    end

    // A flip edge landing on the tick itself is served immediately, hence the OR with flip_pulse.
    always_comb begin
        bus.player_en    = in_run;
        bus.move_tick    = move_tick;
        bus.grv_req      = move_tick && !fatal_tick && bus.collision && (pending_reg || flip_pulse);
        bus.state        = state_reg;
        bus.score        = score_reg;
        bus.player_rst_n = player_rst_n_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_reg     <= '0;
            die_cnt_reg      <= '0;
            pending_reg      <= 1'b0;
            score_reg        <= '0;
            player_rst_n_reg <= 1'b0;
        end else begin
            if (in_run) begin
                tick_cnt_reg <= move_tick ? '0 : tick_cnt_reg + 1'b1;
            end else begin
                tick_cnt_reg <= '0;
            end

            if (state_reg == ST_DYING) begin
                die_cnt_reg <= (die_cnt_reg == DieLast) ? '0 : die_cnt_reg + 1'b1;
            end else begin
                die_cnt_reg <= '0;
            end

            // At most one request is held, and only until the next tick.
            if (!in_run || move_tick) begin
                pending_reg <= 1'b0;
            end else if (flip_pulse) begin
                pending_reg <= 1'b1;
            end

            if (run_entry) begin
                score_reg <= '0;
            end else if (move_tick && !fatal_tick) begin
                score_reg <= score_sat_inc(score_reg);
            end

            player_rst_n_reg <= !run_entry;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised bench for game_ctrl, checked cycle by cycle against a model that
// tracks run age / dying age and derives ticks from modulo arithmetic.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int TD = 4;
    localparam int DC = 8;
    localparam int TL = 44;
    localparam int BL = 479;

    logic clk = 1'b0;
    logic rst = 1'b1;

    game_ctrl_if bus();

    game_ctrl #(
        .TickDiv     (TD),
        .TopLimit    (TL),
        .BottomLimit (BL),
        .DieCycles   (DC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit m_valid     = 1'b0;
    int m_state     = 0;
    int m_run_age   = 0;
    int m_die_age   = 0;
    int m_score     = 0;
    bit m_pending   = 1'b0;
    bit m_start_prv = 1'b0;
    bit m_flip_prv  = 1'b0;
    bit m_start_ev  = 1'b0;
    bit m_flip_ev   = 1'b0;
    bit m_after_rst = 1'b0;

    task automatic step(input bit r, input bit s, input bit f, input bit c, input int loc);
        bit run, tick, oob, fatal, grv, prst;
        int n_state, n_run_age, n_die_age, n_score;
        bit n_pending;
        logic [8:0] loc9;
        loc9 = loc[8:0];
        @(negedge clk);
        rst           = r;
        bus.start     = s;
        bus.flip      = f;
        bus.collision = c;
        bus.luc_loc   = loc9;
        #1;
        run   = (m_state == 1);
        tick  = run && ((m_run_age % TD) == TD - 1);
        oob   = (loc <= TL) || (loc >= BL);
        fatal = tick && oob;
        grv   = tick && !fatal && c && (m_pending || m_flip_ev);
        prst  = !m_after_rst && !(run && m_run_age == 0);
        if (m_valid) begin
            check_eq("state",        32'(bus.state),        32'(m_state));
            check_eq("score",        32'(bus.score),        32'(m_score));
            check_eq("move_tick",    32'(bus.move_tick),    32'(tick));
            check_eq("grv_req",      32'(bus.grv_req),      32'(grv));
            check_eq("player_en",    32'(bus.player_en),    32'(run));
            check_eq("player_rst_n", 32'(bus.player_rst_n), 32'(prst));
        end
        n_state   = m_state;
        n_run_age = m_run_age;
        n_die_age = m_die_age;
        n_score   = m_score;
        n_pending = m_pending;
        case (m_state)
            0, 3: if (m_start_ev) begin
                n_state   = 1;
                n_run_age = 0;
                n_score   = 0;
                n_pending = 1'b0;
            end
            1: begin
                if (tick && !fatal && m_score < 65535) n_score = m_score + 1;
                if (fatal) begin
                    n_state   = 2;
                    n_die_age = 0;
                end else begin
                    n_run_age = m_run_age + 1;
                end
                n_pending = tick ? 1'b0 : (m_pending || m_flip_ev);
            end
            default: begin
                if (m_die_age == DC - 1) n_state = 3;
                else n_die_age = m_die_age + 1;
            end
        endcase
        @(posedge clk);
        if (r) begin
            n_state   = 0;
            n_run_age = 0;
            n_die_age = 0;
            n_score   = 0;
            n_pending = 1'b0;
        end
        if (m_valid && n_state != m_state)
            $display("txn t=%0t state %0d->%0d score=%0d", $time, m_state, n_state, n_score);
        m_state     = n_state;
        m_run_age   = n_run_age;
        m_die_age   = n_die_age;
        m_score     = n_score;
        m_pending   = n_pending;
        m_start_ev  = r ? 1'b0 : (s && !m_start_prv);
        m_flip_ev   = r ? 1'b0 : (f && !m_flip_prv);
        m_start_prv = r ? 1'b0 : s;
        m_flip_prv  = r ? 1'b0 : f;
        m_after_rst = r;
        if (r) m_valid = 1'b1;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.flip      = 1'b0;
        bus.collision = 1'b0;
        bus.luc_loc   = 9'd200;

        // Reset, then start: 0->1, one-cycle player reset, tick every 4th cycle
        repeat (2) step(1, 0, 0, 0, 200);
        step(0, 1, 0, 0, 200);
        step(0, 1, 0, 0, 200);
        repeat (12) step(0, 0, 0, 0, 200);

        // Flip with collision: one grant on the next tick only
        step(0, 0, 1, 1, 200);
        repeat (9) step(0, 0, 0, 1, 200);

        // Flip without collision at the tick: dropped, not carried over
        step(0, 0, 1, 0, 200);
        repeat (5) step(0, 0, 0, 0, 200);
        repeat (8) step(0, 0, 0, 1, 200);

        // Bottom limit -> DYING, score frozen, OVER after DC cycles
        repeat (5) step(0, 0, 0, 0, 479);
        repeat (12) step(0, 0, 0, 0, 200);

        // Restart from OVER, score from 0 to 10+
        step(0, 1, 0, 0, 200);
        repeat (45) step(0, 0, 0, 0, 200);

        // Top limit
        repeat (5) step(0, 0, 0, 0, 44);
        repeat (12) step(0, 0, 0, 0, 200);

        // Restart, then reset with a flip pending
        step(0, 1, 0, 1, 200);
        repeat (6) step(0, 0, 0, 1, 200);
        step(0, 0, 1, 1, 200);
        step(0, 0, 0, 1, 200);
        step(0, 0, 0, 1, 200);
        step(1, 0, 0, 1, 200);
        repeat (8) step(0, 0, 0, 1, 200);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, s, f, c;
            int loc;
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 5) == 0);
            f = ($urandom_range(0, 2) == 0);
            c = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                loc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 44)) : int'($urandom_range(479, 511));
            end else begin
                loc = int'($urandom_range(45, 478));
            end
            step(r, s, f, c, loc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TickDiv, default 833333, clock cycles per move tick (60 Hz at 50 MHz).
REQ-002 Parameter TopLimit, default 44, player y at or below which the player is dead.
REQ-003 Parameter BottomLimit, default 479, player y at or above which the player is dead.
REQ-004 Parameter DieCycles, default 25000000, clock cycles spent in DYING before OVER.
REQ-005 clk_i  in  1  single system clock; all logic on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 start_i  in  1  start button level, already synchronised.
REQ-008 flip_i  in  1  gravity button level, already synchronised.
REQ-009 luc_loc_i  in  9  current player y from the player datapath.
REQ-010 collision_i  in  1  player is resting on a line.
REQ-011 player_rst_n_o  out  1  active-low reset to the player datapath.
REQ-012 player_en_o  out  1  player datapath enabled.
REQ-013 move_tick_o  out  1  one-cycle pulse per move step.
REQ-014 grv_req_o  out  1  one-cycle gravity-flip request to the player.
REQ-015 state_o  out  2  current state encoding.
REQ-016 score_o  out  16  ticks survived in the current run.

Function
REQ-017 FSM states SHALL be IDLE=0, RUN=1, DYING=2, OVER=3.
REQ-018 start_i and flip_i SHALL be rising-edge detected; an edge is a one-cycle event on the cycle after the 0->1 transition is sampled.
REQ-019 A start edge in IDLE or OVER SHALL enter RUN next cycle, clear score_o and drive player_rst_n_o low for exactly that first RUN cycle.
REQ-020 Start edges in RUN or DYING SHALL be ignored.
REQ-021 In RUN the tick counter SHALL count 0..TickDiv-1 and wrap; move_tick_o is high only in the cycle where the count equals TickDiv-1.
REQ-022 Outside RUN the tick counter SHALL be held at 0 and move_tick_o SHALL be low.
REQ-023 player_en_o SHALL be high only in RUN.
REQ-024 A flip edge in RUN SHALL set a pending flag; flip edges outside RUN are dropped.
REQ-025 On a move tick with pending set and collision_i=1, grv_req_o SHALL pulse in that same cycle.
REQ-026 Pending SHALL clear on every move tick, whether or not the request was granted; no buffering beyond one tick.
REQ-027 A flip edge coinciding with a move tick SHALL be served on that tick.
REQ-028 On a move tick in RUN, luc_loc_i <= TopLimit or luc_loc_i >= BottomLimit SHALL transition to DYING next cycle; grv_req_o is suppressed on that tick.
REQ-029 score_o SHALL increment by 1 on each non-fatal move tick in RUN and saturate at 16'hFFFF.
REQ-030 score_o SHALL hold its value in DYING and OVER.
REQ-031 DYING SHALL last exactly DieCycles cycles, counted by a dedicated counter, then enter OVER.

Reset
REQ-032 rst_i=1 SHALL force IDLE, counters 0, pending 0, score_o 0, move_tick_o 0, grv_req_o 0, player_en_o 0 and player_rst_n_o 0 on the next edge.
REQ-033 player_rst_n_o SHALL be 1 in all states after reset, except the RUN-entry cycle defined in REQ-019.
REQ-034 Reset mid-RUN or mid-DYING SHALL abandon the run with no residual pulse.

Structure
REQ-035 State encodings and default parameter values SHALL live in the shared package game_pkg.
REQ-036 A sub-module edge_detect SHALL be instantiated once for start_i and once for flip_i.

Verification (TickDiv=4, DieCycles=8, TopLimit=44, BottomLimit=479)
REQ-037 Reset, then start pulse -> state_o goes 0->1, player_rst_n_o low for 1 cycle, move_tick_o every 4th cycle.
REQ-038 Flip edge with collision_i=1 -> grv_req_o pulses once, on the next move tick; a second tick gives no pulse.
REQ-039 Flip edge with collision_i=0 at the tick -> no grv_req_o; pending cleared; collision_i=1 at the next tick -> still no pulse.
REQ-040 luc_loc_i=479 at a tick -> state_o=2 next cycle, score_o frozen, then state_o=3 after 8 cycles.
REQ-041 In OVER, start edge -> RUN with score_o=0; after 10 ticks score_o=10.
REQ-042 rst_i asserted mid-RUN with a flip pending -> IDLE next cycle, grv_req_o never pulses.
